// File: rtl/ring_buffer_sweep_scheduler_pkg.sv
// Shared types and constants for the ring-buffer sweep scheduler.
// Optional feature macro used by the top: RBSCHED_OVERRUN_CNT_EN.
package ring_buffer_sweep_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_SWEEP = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_t;

    // Cycles from a read strobe to its returned data beat.
    localparam int RB_READ_LATENCY = 2;

endpackage

// File: rtl/ring_buffer_sweep_scheduler_tap_return_tracker.sv
// Counts returned ring-buffer beats against the sweep length and tags them
// as an indexed tap stream with last/done markers.
module ring_buffer_sweep_scheduler_tap_return_tracker
    import ring_buffer_sweep_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRSIZE   = 11
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  i_start,
    input  logic                  i_active,
    input  logic                  i_zero_done,
    input  logic [ADDRSIZE:0]     i_len,
    input  logic [DATA_WIDTH-1:0] rb_data,
    input  logic                  rb_data_valid,
    output logic [DATA_WIDTH-1:0] o_tap_data,
    output logic [ADDRSIZE-1:0]   o_tap_index,
    output logic                  o_tap_valid,
    output logic                  o_tap_last,
    output logic                  o_done
);

    localparam logic [ADDRSIZE:0] CNT_ONE = {{ADDRSIZE{1'b0}}, 1'b1};

    logic [ADDRSIZE:0]     r_cnt;
    logic [DATA_WIDTH-1:0] r_tap_data;
    logic [ADDRSIZE-1:0]   r_tap_index;
    logic                  r_tap_valid;
    logic                  r_tap_last;
    logic                  r_done;

    logic                  w_beat;
    logic                  w_final;

    // Beats beyond the expected count (stale returns) are never tagged.
    assign w_beat  = i_active && rb_data_valid && (r_cnt != i_len);
    assign w_final = ((r_cnt + CNT_ONE) == i_len);

    // Return counter and registered tap stream.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cnt       <= {(ADDRSIZE+1){1'b0}};
            r_tap_data  <= {DATA_WIDTH{1'b0}};
            r_tap_index <= {ADDRSIZE{1'b0}};
            r_tap_valid <= 1'b0;
            r_tap_last  <= 1'b0;
            r_done      <= 1'b0;
        end else if (i_start) begin
            r_cnt       <= {(ADDRSIZE+1){1'b0}};
            r_tap_valid <= 1'b0;
            r_tap_last  <= 1'b0;
            r_done      <= 1'b0;
        end else if (w_beat) begin
            r_cnt       <= r_cnt + CNT_ONE;
            r_tap_data  <= rb_data;
            r_tap_index <= r_cnt[ADDRSIZE-1:0];
            r_tap_valid <= 1'b1;
            r_tap_last  <= w_final;
            r_done      <= w_final;
        end else begin
            r_tap_valid <= 1'b0;
            r_tap_last  <= 1'b0;
            r_done      <= i_zero_done;
        end
    end

    assign o_tap_data  = r_tap_data;
    assign o_tap_index = r_tap_index;
    assign o_tap_valid = r_tap_valid;
    assign o_tap_last  = r_tap_last;
    assign o_done      = r_done;

endmodule

// File: rtl/ring_buffer_sweep_scheduler.sv
// Sole master of the sample ring buffer: one shift per sample strobe, then a
// read burst over the newest L samples. Optional macro: RBSCHED_OVERRUN_CNT_EN.
module ring_buffer_sweep_scheduler
    import ring_buffer_sweep_scheduler_pkg::*;
#(
    parameter int ENTRIES    = 2048,
    parameter int DATA_WIDTH = 32,
    parameter int ADDRSIZE   = $clog2(ENTRIES)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid_in,
    input  logic [ADDRSIZE:0]     sweep_len_in,
    output logic                  busy_out,
    output logic [DATA_WIDTH-1:0] rb_shift_data,
    output logic                  rb_shift_trigger,
    output logic [ADDRSIZE-1:0]   rb_read_addr,
    output logic                  rb_read_trigger,
    input  logic [DATA_WIDTH-1:0] rb_data,
    input  logic                  rb_data_valid,
    output logic [DATA_WIDTH-1:0] tap_data_out,
    output logic [ADDRSIZE-1:0]   tap_index_out,
    output logic                  tap_valid_out,
    output logic                  tap_last_out,
    output logic                  sweep_done_out
`ifdef RBSCHED_OVERRUN_CNT_EN
    ,
    output logic [15:0]           overrun_count_out
`endif
);

    localparam logic [ADDRSIZE:0]   LEN_MAX  = (ADDRSIZE+1)'(ENTRIES);
    localparam logic [ADDRSIZE:0]   LEN_ZERO = {(ADDRSIZE+1){1'b0}};
    localparam logic [ADDRSIZE:0]   CNT_ONE  = {{ADDRSIZE{1'b0}}, 1'b1};
    localparam logic [ADDRSIZE-1:0] ADDR_ONE = {{(ADDRSIZE-1){1'b0}}, 1'b1};

    sched_state_t          r_state;
    logic [ADDRSIZE:0]     r_len;
    logic [ADDRSIZE:0]     r_rd_cnt;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_shift_data;
    logic                  r_shift_trig;
    logic [ADDRSIZE-1:0]   r_rd_addr;
    logic                  r_rd_trig;

    logic                  w_start;
    logic                  w_active;
    logic                  w_zero_done;
    logic                  w_done;
    logic [ADDRSIZE:0]     w_len_clamp;
    logic [ADDRSIZE-1:0]   w_base;

    assign w_start     = (r_state == ST_IDLE) && sample_valid_in;
    assign w_active    = (r_state == ST_SWEEP) || (r_state == ST_DRAIN);
    assign w_zero_done = (r_state == ST_SHIFT) && (r_len == LEN_ZERO);
    assign w_len_clamp = (sweep_len_in > LEN_MAX) ? LEN_MAX : sweep_len_in;
    // Modulo-ENTRIES start address: L = ENTRIES wraps to 0.
    assign w_base      = ADDRSIZE'(LEN_MAX - r_len);

    // Sweep sequencer: strobe latch, shift, read-address generation, drain.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_len        <= LEN_ZERO;
            r_rd_cnt     <= LEN_ZERO;
            r_busy       <= 1'b0;
            r_shift_data <= {DATA_WIDTH{1'b0}};
            r_shift_trig <= 1'b0;
            r_rd_addr    <= {ADDRSIZE{1'b0}};
            r_rd_trig    <= 1'b0;
        end else begin
            r_shift_trig <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sample_valid_in) begin
                        r_shift_data <= sample_in;
                        r_shift_trig <= 1'b1;
                        r_len        <= w_len_clamp;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SHIFT;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (r_len == LEN_ZERO) begin
                        r_rd_cnt <= LEN_ZERO;
                        r_state  <= ST_DRAIN;
                    end else begin
                        r_rd_trig <= 1'b1;
                        r_rd_addr <= w_base;
                        r_rd_cnt  <= CNT_ONE;
                        r_state   <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (r_rd_cnt == r_len) begin
                        r_rd_trig <= 1'b0;
                        r_state   <= ST_DRAIN;
                    end else begin
                        r_rd_trig <= 1'b1;
                        r_rd_addr <= r_rd_addr + ADDR_ONE;
                        r_rd_cnt  <= r_rd_cnt + CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (w_done) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_busy <= 1'b1;
                    end
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_rd_trig <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    ring_buffer_sweep_scheduler_tap_return_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDRSIZE   (ADDRSIZE)
    ) u_tracker (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .i_start       (w_start),
        .i_active      (w_active),
        .i_zero_done   (w_zero_done),
        .i_len         (r_len),
        .rb_data       (rb_data),
        .rb_data_valid (rb_data_valid),
        .o_tap_data    (tap_data_out),
        .o_tap_index   (tap_index_out),
        .o_tap_valid   (tap_valid_out),
        .o_tap_last    (tap_last_out),
        .o_done        (w_done)
    );

    assign busy_out         = r_busy;
    assign rb_shift_data    = r_shift_data;
    assign rb_shift_trigger = r_shift_trig;
    assign rb_read_addr     = r_rd_addr;
    assign rb_read_trigger  = r_rd_trig;
    assign sweep_done_out   = w_done;

`ifdef RBSCHED_OVERRUN_CNT_EN
    logic [15:0] r_overrun;

    // Saturating count of strobes dropped while a sweep is in progress.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_overrun <= 16'h0000;
        end else if (sample_valid_in && (r_state != ST_IDLE) && (r_overrun != 16'hFFFF)) begin
            r_overrun <= r_overrun + 16'h0001;
        end else begin
            r_overrun <= r_overrun;
        end
    end

    assign overrun_count_out = r_overrun;
`endif

endmodule

// File: tb/tb_ring_buffer_sweep_scheduler.sv
// Randomized bench: behavioural ring buffer plus a sample-history model that
// predicts every cycle of each sweep from the documented timing.
module tb_ring_buffer_sweep_scheduler;

    localparam int ENTRIES = 16;
    localparam int AW      = 4;
    localparam int DW      = 32;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [DW-1:0] sample_in;
    logic          sample_valid_in;
    logic [AW:0]   sweep_len_in;
    logic          busy_out;
    logic [DW-1:0] rb_shift_data;
    logic          rb_shift_trigger;
    logic [AW-1:0] rb_read_addr;
    logic          rb_read_trigger;
    logic [DW-1:0] rb_data;
    logic          rb_data_valid;
    logic [DW-1:0] tap_data_out;
    logic [AW-1:0] tap_index_out;
    logic          tap_valid_out;
    logic          tap_last_out;
    logic          sweep_done_out;
`ifdef RBSCHED_OVERRUN_CNT_EN
    logic [15:0]   overrun_count_out;
`endif

    ring_buffer_sweep_scheduler #(.ENTRIES(ENTRIES), .DATA_WIDTH(DW)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .sample_in         (sample_in),
        .sample_valid_in   (sample_valid_in),
        .sweep_len_in      (sweep_len_in),
        .busy_out          (busy_out),
        .rb_shift_data     (rb_shift_data),
        .rb_shift_trigger  (rb_shift_trigger),
        .rb_read_addr      (rb_read_addr),
        .rb_read_trigger   (rb_read_trigger),
        .rb_data           (rb_data),
        .rb_data_valid     (rb_data_valid),
        .tap_data_out      (tap_data_out),
        .tap_index_out     (tap_index_out),
        .tap_valid_out     (tap_valid_out),
        .tap_last_out      (tap_last_out),
`ifdef RBSCHED_OVERRUN_CNT_EN
        .overrun_count_out (overrun_count_out),
`endif
        .sweep_done_out    (sweep_done_out)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural ring buffer: head advances after a shift, 2-cycle read latency.
    logic [DW-1:0] mem [ENTRIES] = '{default: '0};
    int            wp = 0;
    logic          s1_v = 1'b0, s2_v = 1'b0, spur = 1'b0;
    logic [DW-1:0] s1_d = '0, s2_d = '0;

    always @(posedge clk_in) begin
        if (rb_shift_trigger) begin
            mem[wp] <= rb_shift_data;
            wp      <= (wp + 1) % ENTRIES;
        end
        s1_v <= rb_read_trigger;
        s1_d <= mem[(wp + int'(rb_read_addr)) % ENTRIES];
        s2_v <= s1_v;
        s2_d <= s1_d;
    end

    assign rb_data_valid = s2_v | spur;
    assign rb_data       = s2_d;

    logic [DW-1:0] hist[$];
    int n_checks = 0;
    int n_pass   = 0;
    int exp_ovr  = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, busy_out, 0);
        check_val({tag, "_shtrig"}, rb_shift_trigger, 0);
        check_val({tag, "_shdata"}, rb_shift_data, 0);
        check_val({tag, "_rdtrig"}, rb_read_trigger, 0);
        check_val({tag, "_rdaddr"}, rb_read_addr, 0);
        check_val({tag, "_tdata"}, tap_data_out, 0);
        check_val({tag, "_tidx"}, tap_index_out, 0);
        check_val({tag, "_tvalid"}, tap_valid_out, 0);
        check_val({tag, "_tlast"}, tap_last_out, 0);
        check_val({tag, "_done"}, sweep_done_out, 0);
`ifdef RBSCHED_OVERRUN_CNT_EN
        check_val({tag, "_ovr"}, overrun_count_out, 0);
`endif
    endtask

    task automatic idle(input int n, input bit use_spur);
        for (int i = 0; i < n; i++) begin
            check_val("idle_busy", busy_out, 0);
            check_val("idle_tvalid", tap_valid_out, 0);
            check_val("idle_done", sweep_done_out, 0);
            spur = use_spur ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        spur = 1'b0;
    endtask

    // Strobe issued in the current cycle; every following cycle is predicted.
    task automatic do_sweep(input logic [DW-1:0] val, input int len_in, input int inj, input int rst_at);
        int L, last;
        bit rd, tv;
        logic [DW-1:0] exp_tap[$];
        L    = (len_in > ENTRIES) ? ENTRIES : len_in;
        last = (L == 0) ? 2 : L + 4;
        sample_in       = val;
        sweep_len_in    = (AW+1)'(len_in);
        sample_valid_in = 1'b1;
        hist.push_back(val);
        for (int k = 0; k < L; k++) exp_tap.push_back(hist[hist.size() - L + k]);
        tick();
        sample_valid_in = 1'b0;
        for (int c = 1; c <= last; c++) begin
            rd = (c >= 2) && (c <= L + 1);
            tv = (c >= 5) && (c <= L + 4);
            check_val("busy", busy_out, 1);
            check_val("shift_trig", rb_shift_trigger, (c == 1));
            if (c == 1) check_val("shift_data", rb_shift_data, val);
            check_val("rd_trig", rb_read_trigger, rd);
            if (rd) check_val("rd_addr", rb_read_addr, (ENTRIES - L + c - 2) % ENTRIES);
            check_val("tap_valid", tap_valid_out, tv);
            if (tv) begin
                check_val("tap_data", tap_data_out, exp_tap[c - 5]);
                check_val("tap_index", tap_index_out, c - 5);
            end
            check_val("tap_last", tap_last_out, tv && (c == L + 4));
            check_val("done", sweep_done_out, (c == last));
            if (c == rst_at) begin
                rst_in = 1'b1;
                #1;
                check_all_zero("rst_mid");
                exp_ovr = 0;
                tick();
                tick();
                rst_in = 1'b0;
                idle(8, 1'b0);
                return;
            end
            if (c == inj) begin
                sample_in       = $urandom;
                sample_valid_in = 1'b1;
                if (exp_ovr < 65535) exp_ovr++;
            end else begin
                sample_valid_in = 1'b0;
            end
            tick();
        end
        sample_valid_in = 1'b0;
        check_val("end_busy", busy_out, 0);
        check_val("end_done", sweep_done_out, 0);
        check_val("end_tvalid", tap_valid_out, 0);
`ifdef RBSCHED_OVERRUN_CNT_EN
        check_val("overrun", overrun_count_out, exp_ovr);
`endif
    endtask

    initial begin
        rst_in          = 1'b1;
        sample_in       = '0;
        sample_valid_in = 1'b0;
        sweep_len_in    = '0;
        for (int i = 0; i < ENTRIES; i++) hist.push_back('0);
        tick();
        check_all_zero("reset");
        tick();
        rst_in = 1'b0;
        idle(2, 1'b0);

        // Preload 0..15 with zero-length sweeps, back to back.
        for (int i = 0; i < ENTRIES; i++) do_sweep(DW'(i), 0, 0, 0);
        do_sweep(32'd100, 4, 0, 0);            // basic: 13,14,15,100
        for (int i = 0; i < 4; i++) do_sweep($urandom, 0, 0, 0);
        do_sweep($urandom, 16, 0, 0);          // full sweep
        idle(2, 1'b1);
        do_sweep($urandom, 31, 0, 0);          // clamp to 16
        idle(1, 1'b0);
        do_sweep($urandom, 4, 3, 0);           // overrun at cycle 3
        do_sweep($urandom, 4, 0, 0);           // back-to-back at cycle 9
        do_sweep($urandom, 8, 0, 3);           // reset mid-sweep
        do_sweep($urandom, 5, 0, 0);
        idle(3, 1'b1);

        for (int n = 0; n < 15; n++) begin
            do_sweep($urandom, $urandom_range(0, 31),
                     ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0, 0);
            idle($urandom_range(0, 3), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ring_buffer_sweep_scheduler.md
# ring_buffer_sweep_scheduler

Sequences the shared sample ring buffer for one audio sample period. On each incoming sample strobe it performs one write (shift) into the ring buffer. It then issues a burst of reads covering the most recent `sweep_len` samples, oldest first. It tags the returning data as an indexed tap stream for the pitch-detection datapath. It is the only master of the ring buffer's write and read ports, and it sits between the audio sample source and the autocorrelation/difference engine.

## Interface
- `ENTRIES`, default 2048: ring buffer depth; must equal the connected buffer's depth and be a power of two.
- `DATA_WIDTH`, default 32: sample width.
- `ADDRSIZE`, derived as $clog2(ENTRIES): ring buffer address width.
- `clk_in`, in, 1: the single clock.
- `rst_in`, in, 1: reset, asynchronous and active-high.
- `sample_in`, in, DATA_WIDTH: audio sample; sampled on a valid strobe.
- `sample_valid_in`, in, 1: single-cycle sample strobe.
- `sweep_len_in`, in, ADDRSIZE+1: number of taps to read; latched at strobe acceptance.
- `busy_out`, out, 1: sweep in progress; a strobe received while high is dropped.
- `rb_shift_data`, out, DATA_WIDTH: drives ring buffer write data.
- `rb_shift_trigger`, out, 1: drives ring buffer write strobe.
- `rb_read_addr`, out, ADDRSIZE: drives the ring buffer head-relative read address.
- `rb_read_trigger`, out, 1: drives ring buffer read strobe.
- `rb_data`, in, DATA_WIDTH: ring buffer read data.
- `rb_data_valid`, in, 1: ring buffer read-data valid; fixed 2-cycle latency from `rb_read_trigger`.
- `tap_data_out`, out, DATA_WIDTH: tap sample.
- `tap_index_out`, out, ADDRSIZE: tap index; 0 is the oldest tap in the sweep.
- `tap_valid_out`, out, 1: tap qualifier. There is no backpressure, and the consumer must accept one tap per cycle.
- `tap_last_out`, out, 1: marks the final tap of a sweep.
- `sweep_done_out`, out, 1: one-cycle pulse that ends each sweep.

## Operation
- The FSM has four states: IDLE, SHIFT, SWEEP and DRAIN. Every output is registered.
- **IDLE:** `sample_valid_in`=1 latches the sample and the effective length `L`, then moves to SHIFT.
  - `L` = `sweep_len_in` clamped to ENTRIES.
- **SHIFT:** one cycle with `rb_shift_trigger`=1 and `rb_shift_data`=latched sample.
  - If `L`=0, go to DRAIN with no reads issued.
  - Otherwise go to SWEEP.
- **SWEEP:** `L` consecutive cycles with `rb_read_trigger`=1 and `rb_read_addr` = ENTRIES−L+k, for k = 0..L−1.
  - The arithmetic is ADDRSIZE-bit modulo, so `L`=ENTRIES gives addresses 0..ENTRIES−1.
  - After the last read, go to DRAIN.
- **DRAIN:** waits until the returned-tap count reaches `L`.
  - Each `rb_data_valid` beat registers `tap_data_out`=`rb_data`, `tap_valid_out`=1 and `tap_index_out`=return count.
  - `tap_last_out`=1 on index L−1, in the same cycle as the `sweep_done_out` pulse.
  - For `L`=0, `sweep_done_out` pulses on the first DRAIN cycle with no taps.
  - Then return to IDLE.
- `busy_out`=1 in every state except IDLE.
  - A strobe arriving while busy is dropped and the ring buffer is not written.
  - A strobe in the same cycle the FSM returns to IDLE is accepted.
- `rb_data_valid` arriving in IDLE is ignored.
- **Reset (any state):** FSM goes to IDLE; counters clear; all outputs go to 0. In-flight read data is discarded.

## Timing
- Strobe accepted at cycle 0.
- Cycle 1: shift.
- Cycles 2..L+1: reads.
- Cycles 4..L+3: `rb_data_valid`.
- Cycles 5..L+4: `tap_valid_out`.
- Cycle L+4: `tap_last_out` and `sweep_done_out`.
- `busy_out` is high for cycles 1..L+4, so the minimum strobe spacing is L+5 cycles.
- For `L`=0: shift at cycle 1, `sweep_done_out` at cycle 2, `busy_out` high for cycles 1..2.
- The buffer head advances the cycle after the shift, so read k=L−1 returns the newly written sample.

## Configuration
- **`RBSCHED_OVERRUN_CNT_EN` defined:** adds output `overrun_count_out` [15:0], with reset value 0.
  - It increments on each strobe dropped while `busy_out`=1.
  - It saturates at 16'hFFFF.
- **Not defined:** the port and counter are absent. Dropped strobes are silent and all other behaviour is identical.

## Structure
- The shared package holds:
  - the FSM state enum (IDLE, SHIFT, SWEEP, DRAIN);
  - the read-latency constant `RB_READ_LATENCY` = 2.
- One natural sub-module is `tap_return_tracker`, which counts returned beats against `L` and generates the index, last and done signals.
- Top level: FSM, address generator, strobe latch.

## Test plan
- **Basic sweep:** ENTRIES=16, preload 0..15 by strobing with L=0, then strobe value 100 with L=4.
  - Required: taps 13,14,15,100, indices 0..3, last on the fourth tap, done at cycle 8.
- **Full sweep:** L=16 after 20 writes.
  - Required: 16 taps equal to the last 16 samples, oldest first; addresses 0..15.
- **Clamp:** `sweep_len_in`=31 with ENTRIES=16.
  - Required: exactly 16 taps, `busy_out` high for 20 cycles.
- **Overrun:** a second strobe at cycle 3 of an L=4 sweep.
  - Required: no second shift; `overrun_count_out`=1 when the macro is defined.
  - Back-to-back strobe at cycle 9: accepted.
- **Reset mid-SWEEP:** assert `rst_in` at cycle 3 of an L=8 sweep.
  - Required: all outputs 0 immediately; no taps after release.
  - The next sweep produces correct indices starting at 0.
- **Zero length:** L=0.
  - Required: one shift, `sweep_done_out` at cycle 2, no `tap_valid_out`.
